systolic_matmul_core: RTL and testbench
=======================================

// Module: systolic_matmul_core
// PURPOSE
//  Parametrised NxN weight-stationary systolic matmul engine with run sequencing.
//  Internally contains the PE array, input skew and output deskew stages.
//  Per run: captures an NxN weight tile, streams num_rows activation rows in, and returns one result row per input row.
//  Rows move over valid/ready handshakes, so a unified-buffer or DMA front end can drive it directly.
// PARAMETERS
//  N   2   array dimension (rows = cols = N), N>=1
//  DW  16  operand width, signed two's complement
//  AW  32  accumulator/result width, AW >= 2*DW
//  RW  8   width of num_rows and of the internal row counters
// PORTS
//  clk       in   1       clock, rising edge
//  reset     in   1       asynchronous, active-low reset
//  start     in   1       begin a run; sampled only in IDLE
//  num_rows  in   RW      activation rows in this run; sampled with start
//  w_flat    in   N*N*DW  W[k][j] at [(k*N+j)*DW +: DW]; sampled with start
//  a_valid   in   1       a_row holds a valid activation row
//  a_ready   out  1       core accepts a_row this cycle
//  a_row     in   N*DW    a[k] at [k*DW +: DW]
//  r_valid   out  1       r_row holds a valid result row
//  r_ready   in   1       sink accepts r_row this cycle
//  r_row     out  N*AW    r[j] at [j*AW +: AW]
//  busy      out  1       high in any state except IDLE
//  done      out  1       one-cycle pulse when a run completes
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state IDLE; a_ready=0, r_valid=0, r_row=0, busy=0, done=0.
//    All PE weights, pipeline registers, valid tags and counters are cleared.
//  Math: r[j] = sum over k of a[k]*W[k][j].
//    Each product is the full signed 2*DW value, sign-extended to AW; sums wrap modulo 2^AW.
//  FSM states: IDLE, LOAD, STREAM, DRAIN.
//    IDLE: start=1 and num_rows!=0 -> LOAD; capture w_flat and num_rows.
//      start=1 and num_rows==0 -> stay IDLE; pulse done next cycle; no output.
//    LOAD: one cycle; writes captured weights into the PEs -> STREAM.
//    STREAM: accepts rows until num_rows are accepted -> DRAIN.
//    DRAIN: runs until num_rows results have been handshaken -> IDLE, with done=1 that cycle.
//    start is ignored whenever state != IDLE.
//  Advance (adv): the whole array, skew, deskew and valid-tag pipeline move only on adv.
//    out_ok = !r_valid || r_ready.
//    adv = out_ok && ((STREAM && a_valid) || DRAIN).
//    In DRAIN the array is fed zero rows tagged invalid.
//    a_ready = STREAM && out_ok, combinational; no row is taken in LOAD or DRAIN.
//    a_valid=0 in STREAM freezes the pipeline: bubbles are never inserted.
//  Latency: the result of an accepted row lands in r_row after exactly 2*N adv steps.
//    With no stalls, r_valid rises 2*N cycles after the accept cycle.
//    Results keep input order.
//  Output hold: while r_valid=1 and r_ready=0, r_row stays stable and no adv occurs.
//    r_valid clears after a handshake unless a new valid result lands in the same cycle.
//  Weights are stationary for the whole run; w_flat changes mid-run have no effect.
//  done: registered one-cycle pulse; busy=0 in the done cycle.
//    start is accepted in the done cycle.
//  Reset mid-run: immediate abort to the reset values; in-flight results are lost.
// TESTING
//  1. N=2, W=[[1,2],[3,4]], rows [1,1],[2,-1], r_ready=1, a_valid=1.
//     -> r_row [4,6] then [-1,0].
//     -> first r_valid 4 cycles after the first accept; done 1 cycle after the 2nd handshake.
//  2. Same run with r_ready=0 for 10 cycles once r_valid=1.
//     -> r_row held stable; a_ready=0 during the stall.
//     -> after release, all results arrive in order; none lost or duplicated.
//  3. 8 rows with random a_valid gaps and random r_ready.
//     -> results match the golden matmul exactly.
//     -> the accept-to-result distance counted in adv steps is always 4.
//  4. DW=16, AW=32, all W and a = -32768, N=2.
//     -> every r[j] = 32'h8000_0000 (2^31, wrapped).
//  5. start with num_rows=0 -> done pulse next cycle, busy stays 0, no r_valid.
//     start asserted while busy -> ignored; the current run completes unchanged.
//  6. Drop reset to 0 mid-STREAM.
//     -> all outputs 0 and state IDLE immediately.
//     -> a following run with new weights gives correct results.

Source files
------------

// File: rtl/systolic_matmul_core.sv
// Weight-stationary NxN systolic matmul engine: skewed activations flow right, partial sums flow down,
// deskewed results leave through a held valid/ready output register. Run sequencing by a small FSM.
module systolic_matmul_core #(
    parameter int N  = 2,
    parameter int DW = 16,
    parameter int AW = 32,
    parameter int RW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [RW-1:0]     num_rows,
    input  logic [N*N*DW-1:0] w_flat,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [N*DW-1:0]   a_row,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [N*AW-1:0]   r_row,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

    state_t               state, state_nx;
    logic                 done_nx;
    logic [RW-1:0]        rows_q, acc_cnt, res_cnt;
    logic [N*N*DW-1:0]    w_cap;
    logic                 out_ok, adv, accept, r_fire, last_acc, last_res;
    logic [2*N-2:0]       vtag;
    logic signed [DW-1:0] x_in [N][N];
    logic [AW-1:0]        psum [N][N];
    logic [AW-1:0]        desk_out [N];

    assign out_ok   = !r_valid || r_ready;
    assign adv      = out_ok && ((state == STREAM && a_valid) || state == DRAIN);
    assign accept   = (state == STREAM) && a_valid && out_ok;
    assign a_ready  = (state == STREAM) && out_ok;
    assign r_fire   = r_valid && r_ready;
    assign busy     = (state != IDLE);
    assign last_acc = (acc_cnt == rows_q - RW'(1));
    assign last_res = (res_cnt == rows_q - RW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_rows != '0) state_nx = LOAD;
                    else                done_nx  = 1'b1;
                end
            end
            LOAD:   state_nx = STREAM;
            STREAM: if (accept && last_acc) state_nx = DRAIN;
            DRAIN: begin
                if (r_fire && last_res) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_q  <= '0;
            acc_cnt <= '0;
            res_cnt <= '0;
            w_cap   <= '0;
        end else if (state == IDLE && start && num_rows != '0) begin
            rows_q  <= num_rows;
            w_cap   <= w_flat;
            acc_cnt <= '0;
            res_cnt <= '0;
        end else begin
            if (accept)          acc_cnt <= acc_cnt + RW'(1);
            if (r_fire && busy)  res_cnt <= res_cnt + RW'(1);
        end
    end

    // Row k of the activation vector is delayed k steps so it meets the partial sums of rows above it.
    for (genvar k = 0; k < N; k++) begin : g_skew
        logic signed [DW-1:0] feed;
        assign feed = (state == STREAM) ? a_row[k*DW +: DW] : '0;
        if (k == 0) begin : g_direct
            assign x_in[k][0] = feed;
        end else begin : g_delay
            logic signed [DW-1:0] sr [k];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < k; i++) sr[i] <= '0;
                end else if (adv) begin
                    sr[0] <= feed;
                    for (int i = 1; i < k; i++) sr[i] <= sr[i-1];
                end
            end
            assign x_in[k][0] = sr[k-1];
        end
    end

    for (genvar gk = 0; gk < N; gk++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_pe
            logic signed [DW-1:0]   w_q;
            logic [AW-1:0]          ps_q, up;
            logic signed [2*DW-1:0] prod;
            if (gk == 0) begin : g_top
                assign up = '0;
            end else begin : g_mid
                assign up = psum[gk-1][gj];
            end
            assign prod         = (2*DW)'(x_in[gk][gj]) * (2*DW)'(w_q);
            assign psum[gk][gj] = ps_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    w_q  <= '0;
                    ps_q <= '0;
                end else begin
                    if (state == LOAD) w_q  <= w_cap[(gk*N+gj)*DW +: DW];
                    if (adv)           ps_q <= up + AW'(prod);
                end
            end
            // The last column has no right neighbour, so its activation is not re-registered.
            if (gj < N-1) begin : g_hop
                logic signed [DW-1:0] a_q;
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset)   a_q <= '0;
                    else if (adv) a_q <= x_in[gk][gj];
                end
                assign x_in[gk][gj+1] = a_q;
            end
        end
    end

    for (genvar gj = 0; gj < N; gj++) begin : g_deskew
        localparam int D = N - 1 - gj;
        if (D == 0) begin : g_direct
            assign desk_out[gj] = psum[N-1][gj];
        end else begin : g_delay
            logic [AW-1:0] dq [D];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < D; i++) dq[i] <= '0;
                end else if (adv) begin
                    dq[0] <= psum[N-1][gj];
                    for (int i = 1; i < D; i++) dq[i] <= dq[i-1];
                end
            end
            assign desk_out[gj] = dq[D-1];
        end
    end

    // Valid tags ride alongside the data; drain rows enter tagged invalid so they never surface.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vtag    <= '0;
            r_valid <= 1'b0;
            r_row   <= '0;
        end else if (adv) begin
            vtag[0] <= (state == STREAM);
            for (int i = 1; i < 2*N-1; i++) vtag[i] <= vtag[i-1];
            r_valid <= vtag[2*N-2];
            for (int j = 0; j < N; j++) r_row[j*AW +: AW] <= desk_out[j];
        end else if (r_fire) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_matmul_core.sv
// Directed bench for systolic_matmul_core: a cycle-level protocol model with a golden matmul
// scoreboard checks every output each cycle, plus literal expectations for the named scenarios.
module tb_systolic_matmul_core;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int RW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [RW-1:0]     num_rows;
    logic [N*N*DW-1:0] w_flat;
    logic              a_valid;
    logic              a_ready;
    logic [N*DW-1:0]   a_row;
    logic              r_valid;
    logic              r_ready;
    logic [N*AW-1:0]   r_row;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rr_mode = 0;

    logic [N*AW-1:0]   exp_q [$];
    int                cnt_q [$];
    logic [N*AW-1:0]   got [$];
    logic [N*N*DW-1:0] run_w;
    logic              busy_m, done_m, in_load;
    int                accepted, run_rows, res_run;
    int                first_acc, first_val, last_hs_cyc, done_cyc;

    systolic_matmul_core #(.N(N), .DW(DW), .AW(AW), .RW(RW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .w_flat(w_flat),
        .a_valid(a_valid), .a_ready(a_ready), .a_row(a_row), .r_valid(r_valid),
        .r_ready(r_ready), .r_row(r_row), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (rr_mode)
            0:       r_ready = 1'b1;
            1:       r_ready = 1'($urandom_range(0, 1));
            default: r_ready = 1'b0;
        endcase
    end

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N*DW-1:0] pack_a(input int x0, input int x1);
        logic [N*DW-1:0] v;
        v[0  +: DW] = DW'(x0);
        v[DW +: DW] = DW'(x1);
        return v;
    endfunction

    function automatic logic [N*AW-1:0] pack_r(input int r0, input int r1);
        logic [N*AW-1:0] v;
        v[0  +: AW] = AW'(r0);
        v[AW +: AW] = AW'(r1);
        return v;
    endfunction

    function automatic logic [N*N*DW-1:0] pack_w(input int w00, input int w01, input int w10, input int w11);
        logic [N*N*DW-1:0] v;
        v[0*DW +: DW] = DW'(w00);
        v[1*DW +: DW] = DW'(w01);
        v[2*DW +: DW] = DW'(w10);
        v[3*DW +: DW] = DW'(w11);
        return v;
    endfunction

    // Golden row: r[j] = sum_k a[k]*W[k][j], wrapped to AW bits.
    function automatic logic [N*AW-1:0] model_row(input logic [N*DW-1:0] a, input logic [N*N*DW-1:0] w);
        logic [N*AW-1:0] res;
        longint s;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++)
                s += longint'($signed(a[k*DW +: DW])) * longint'($signed(w[(k*N+j)*DW +: DW]));
            res[j*AW +: AW] = s[AW-1:0];
        end
        return res;
    endfunction

    // Protocol model: predicts busy/done/a_ready/r_valid and the result stream every cycle.
    always @(negedge clk) begin
        logic exp_valid, out_ok_m, exp_ar, hs_a, hs_r, drain_m, adv_m, start_ok, nxt_busy, nxt_done, last;
        if (!reset) begin
            exp_q.delete();
            cnt_q.delete();
            busy_m = 1'b0; done_m = 1'b0; in_load = 1'b0;
            accepted = 0; run_rows = 0; res_run = 0;
        end else begin
            exp_valid = (exp_q.size() > 0) && (cnt_q[0] == 2*N);
            out_ok_m  = !exp_valid || r_ready;
            exp_ar    = busy_m && !in_load && (accepted < run_rows) && out_ok_m;
            check_output("r_valid", r_valid, exp_valid);
            if (exp_valid) check_output("r_row", r_row, exp_q[0]);
            check_output("busy", busy, busy_m);
            check_output("done", done, done_m);
            check_output("a_ready", a_ready, exp_ar);
            hs_a     = a_valid && exp_ar;
            hs_r     = exp_valid && r_ready;
            drain_m  = busy_m && !in_load && (accepted == run_rows);
            adv_m    = out_ok_m && (hs_a || drain_m);
            start_ok = start && !busy_m;
            last     = hs_r && (res_run + 1 == run_rows);
            nxt_done = (start_ok && num_rows == 0) || last;
            nxt_busy = busy_m;
            if (start_ok && num_rows != 0) nxt_busy = 1'b1;
            if (last) nxt_busy = 1'b0;
            if (hs_r) begin
                got.push_back(r_row);
                last_hs_cyc = cyc;
                void'(exp_q.pop_front());
                void'(cnt_q.pop_front());
                res_run++;
            end
            if (adv_m) for (int i = 0; i < cnt_q.size(); i++) cnt_q[i] = cnt_q[i] + 1;
            if (hs_a) begin
                exp_q.push_back(model_row(a_row, run_w));
                cnt_q.push_back(1);
                accepted++;
                if (first_acc < 0) first_acc = cyc;
            end
            if (r_valid && first_val < 0) first_val = cyc;
            if (done) done_cyc = cyc;
            in_load = start_ok && (num_rows != 0);
            if (in_load) begin
                run_rows = int'(num_rows);
                accepted = 0;
                res_run  = 0;
                run_w    = w_flat;
            end
            busy_m = nxt_busy;
            done_m = nxt_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n, input logic [N*N*DW-1:0] w, input bit extra);
        start    = 1'b1;
        num_rows = RW'(n);
        w_flat   = w;
        tick();
        if (extra) begin
            num_rows = RW'(5);
            w_flat   = pack_w(9, 9, 9, 9);
            tick();
        end
        start  = 1'b0;
        w_flat = {$urandom, $urandom};
    endtask

    task automatic apply_stimulus(input int x0, input int x1, input int gap);
        bit ok = 0;
        a_valid = 1'b0;
        repeat (gap) tick();
        a_valid = 1'b1;
        a_row   = pack_a(x0, x1);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (a_ready) ok = 1;
        end
        if (!ok) check_output("a_accept_timeout", 0, 1);
        tick();
        a_valid = 1'b0;
        a_row   = '0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check_output("done_seen", seen, 1);
        tick();
    endtask

    task automatic stall_check();
        bit seen = 0;
        logic [N*AW-1:0] held;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (r_valid) seen = 1;
        end
        check_output("stall_rvalid_seen", seen, 1);
        held = r_row;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("stall_r_valid", r_valid, 1);
            check_output("stall_r_row", r_row, held);
            check_output("stall_a_ready", a_ready, 0);
        end
        rr_mode = 0;
    endtask

    initial begin
        logic [N*N*DW-1:0] w1, w3, w4, w5, w6;
        reset = 1'b0; start = 1'b0; num_rows = '0; w_flat = '0; a_valid = 1'b0; a_row = '0;
        first_acc = -1; first_val = -1; last_hs_cyc = 0; done_cyc = 0;
        w1 = pack_w(1, 2, 3, 4);
        w3 = pack_w(7, -3, -11, 5);
        w4 = pack_w(-32768, -32768, -32768, -32768);
        w5 = pack_w(1, 0, 0, -1);
        w6 = pack_w(2, -3, 5, 7);

        check_output("model_pin_a", model_row(pack_a(1, 1), w1), pack_r(4, 6));
        check_output("model_pin_b", model_row(pack_a(2, -1), w1), pack_r(-1, 0));
        check_output("model_pin_wrap", model_row(pack_a(-32768, -32768), w4), {32'h8000_0000, 32'h8000_0000});

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy", busy, 0);
        check_output("reset_r_valid", r_valid, 0);
        check_output("reset_r_row", r_row, 0);
        check_output("reset_a_ready", a_ready, 0);
        check_output("reset_done", done, 0);
        @(negedge clk); #1 reset = 1'b1;
        tick();

        $display("[TB] basic run");
        got.delete(); first_acc = -1; first_val = -1;
        start_run(2, w1, 0);
        apply_stimulus(1, 1, 0);
        apply_stimulus(2, -1, 0);
        wait_done(100);
        check_output("t1_count", got.size(), 2);
        if (got.size() > 1) begin
            check_output("t1_row0", got[0], pack_r(4, 6));
            check_output("t1_row1", got[1], pack_r(-1, 0));
        end
        check_output("t1_latency", first_val - first_acc, 4);
        check_output("t1_done_after_hs", done_cyc - last_hs_cyc, 1);

        $display("[TB] output stall");
        got.delete();
        rr_mode = 2;
        start_run(3, w1, 0);
        fork
            begin
                apply_stimulus(1, 1, 0);
                apply_stimulus(2, -1, 0);
                apply_stimulus(3, 5, 4);
            end
            stall_check();
        join
        wait_done(200);
        check_output("t2_count", got.size(), 3);
        if (got.size() > 2) begin
            check_output("t2_row0", got[0], pack_r(4, 6));
            check_output("t2_row1", got[1], pack_r(-1, 0));
            check_output("t2_row2", got[2], pack_r(18, 26));
        end

        $display("[TB] random gaps and backpressure");
        got.delete();
        rr_mode = 1;
        start_run(8, w3, 0);
        for (int i = 0; i < 8; i++) apply_stimulus(int'($urandom), int'($urandom), int'($urandom_range(0, 2)));
        wait_done(400);
        rr_mode = 0;
        check_output("t3_count", got.size(), 8);

        $display("[TB] wrap corner");
        got.delete();
        start_run(2, w4, 0);
        apply_stimulus(-32768, -32768, 0);
        apply_stimulus(-32768, -32768, 1);
        wait_done(100);
        check_output("t4_count", got.size(), 2);
        for (int i = 0; i < got.size(); i++) check_output("t4_wrap", got[i], {32'h8000_0000, 32'h8000_0000});

        $display("[TB] zero rows and start while busy");
        got.delete();
        start = 1'b1; num_rows = '0; w_flat = w1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check_output("t5_zero_done", done, 1);
        check_output("t5_zero_busy", busy, 0);
        @(negedge clk);
        check_output("t5_zero_done_clear", done, 0);
        check_output("t5_zero_busy2", busy, 0);
        tick();
        start_run(3, w5, 1);
        apply_stimulus(5, 6, 0);
        apply_stimulus(-7, 8, 0);
        apply_stimulus(100, -200, 0);
        wait_done(100);
        check_output("t5_count", got.size(), 3);
        if (got.size() > 2) check_output("t5_row2", got[2], pack_r(100, 200));
        repeat (3) begin
            @(negedge clk);
            check_output("t5_idle_after", busy, 0);
        end
        tick();

        $display("[TB] reset mid-run");
        start_run(4, w1, 0);
        apply_stimulus(1, 2, 0);
        apply_stimulus(3, 4, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check_output("t6_busy", busy, 0);
        check_output("t6_a_ready", a_ready, 0);
        check_output("t6_r_valid", r_valid, 0);
        check_output("t6_r_row", r_row, 0);
        check_output("t6_done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1 reset = 1'b1;
        tick();
        got.delete();
        start_run(2, w6, 0);
        apply_stimulus(4, -2, 0);
        apply_stimulus(-1, 3, 0);
        wait_done(100);
        check_output("t6_count", got.size(), 2);
        if (got.size() > 1) begin
            check_output("t6_row0", got[0], pack_r(-2, -26));
            check_output("t6_row1", got[1], pack_r(13, 24));
        end
        check_output("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
